// File: rtl/serial_crc_checker.sv
// Serial CRC checker: shifts in a message plus its check bits MSB first,
// divides by the generator on the fly and holds the frame result until taken.
module serial_crc_checker #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY = 8'h07
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [CRC_W-1:0]  syndrome,
  output logic              crc_ok,
  output logic [7:0]        err_cnt
);

  localparam int unsigned TOT   = DATA_W + CRC_W;
  localparam int unsigned CNT_W = $clog2(TOT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOT - 1);
  localparam logic [CNT_W-1:0] DLEN = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_n;
  logic [CRC_W-1:0]   r, r_next;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  data;
  logic [7:0]         err;
  logic               accept, last, fb, release_res;

  assign in_ready    = (state != DONE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign last        = accept && (cnt == LAST);
  assign release_res = (state == DONE) && out_ready;

  assign fb     = r[CRC_W-1] ^ in_bit;
  assign r_next = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = last ? DONE : SHIFT;
      SHIFT:   if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r    <= '0;
      cnt  <= '0;
      data <= '0;
      err  <= '0;
    end else begin
      if (accept) begin
        r <= r_next;
        if (!last) cnt <= cnt + CNT_W'(1);
        // Only the message portion lands in data_out; check bits just feed the divider.
        if (cnt < DLEN) data <= {data[DATA_W-2:0], in_bit};
        if (last && (r_next != '0) && (err != 8'hFF)) err <= err + 8'd1;
      end
      if (release_res) begin
        r    <= '0;
        cnt  <= '0;
        data <= '0;
      end
    end
  end

  assign data_out = data;
  assign syndrome = r;
  assign crc_ok   = (r == '0);
  assign err_cnt  = err;

endmodule

// File: tb/tb_serial_crc_checker.sv
// Randomized bench for serial_crc_checker against a polynomial-division model.
module tb_serial_crc_checker;
  localparam int DW = 10;
  localparam int CW = 8;
  localparam int N  = DW + CW;
  localparam logic [63:0] GEN = 64'h107;

  logic clk = 0, reset = 1, in_bit = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, crc_ok;
  logic [DW-1:0] data_out;
  logic [CW-1:0] syndrome;
  logic [7:0] err_cnt;

  int n_cmp = 0, n_bad = 0, acc_mon = 0, err_exp = 0;

  serial_crc_checker #(.DATA_W(DW), .CRC_W(CW), .POLY(8'h07)) dut (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .syndrome(syndrome), .crc_ok(crc_ok), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (in_valid && in_ready) acc_mon++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of v(x) mod x^8+x^2+x+1 by long division.
  function automatic logic [CW-1:0] pmod(input logic [63:0] v);
    for (int i = 63; i >= CW; i--)
      if (v[i]) v = v ^ (GEN << (i - CW));
    return v[CW-1:0];
  endfunction

  // The divider sees the codeword shifted up by CW, so the syndrome is C(x)*x^CW mod G.
  function automatic logic [CW-1:0] model_syn(input logic [N-1:0] cw);
    return pmod(64'(cw) << CW);
  endfunction

  function automatic logic [N-1:0] make_frame(input logic [DW-1:0] d);
    return {d, pmod(64'(d) << CW)};
  endfunction

  task automatic check_result(input logic [N-1:0] cw);
    logic [CW-1:0] s;
    s = model_syn(cw);
    chk("out_valid", out_valid, 1);
    chk("in_ready", in_ready, 0);
    chk("data_out", data_out, cw[N-1:CW]);
    chk("syndrome", syndrome, s);
    chk("crc_ok", crc_ok, s == 0);
    chk("err_cnt", err_cnt, err_exp);
  endtask

  task automatic send(input logic [N-1:0] cw, input int gap, input int nbits);
    int idx = N - 1, cyc = 0, got = 0;
    acc_mon = 0;
    while (got < nbits && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      in_valid = ($urandom_range(99) >= gap);
      in_bit = cw[idx];
      if (in_valid && in_ready) begin idx--; got++; end
    end
    if (cyc >= 2000) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 0;
    if (nbits == N) begin
      if (model_syn(cw) != 0 && err_exp < 255) err_exp++;
      chk("acc_bits", acc_mon, N);
      check_result(cw);
    end
  endtask

  task automatic release_res(input logic [N-1:0] cw, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      out_ready = 0; in_valid = 1; in_bit = $urandom_range(1);
      @(negedge clk);
      in_valid = 0;
      check_result(cw);
      chk("hold_acc", acc_mon, N);
    end
    @(negedge clk);
    out_ready = 1; in_valid = 0;
    @(negedge clk);
    out_ready = 0;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1; in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    err_exp = 0;
    chk("rst_syndrome", syndrome, 0);
    chk("rst_crc_ok", crc_ok, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_err", err_cnt, 0);
    reset = 0;
  endtask

  initial begin
    logic [N-1:0] good, bad, f;
    good = 18'b1010000011_10101010;
    bad  = 18'b1010000011_10101011;

    do_reset();

    send(good, 0, N);
    chk("good_data_const", data_out, 10'h283);
    chk("good_syn_const", syndrome, 8'h00);
    release_res(good, 0);

    send(bad, 0, N);
    chk("bad_syn_const", syndrome, 8'h07);
    chk("bad_err_const", err_cnt, 1);
    release_res(bad, 0);

    send(good, 50, N);
    release_res(good, 5);

    f = make_frame(DW'($urandom));
    send(f, 0, N);
    release_res(f, 0);

    send(good, 30, 9);
    do_reset();
    send(good, 0, N);
    chk("post_rst_ok", crc_ok, 1);
    chk("post_rst_err", err_cnt, 0);
    release_res(good, 0);

    // Reset while a corrupted result is held.
    send(bad, 0, N);
    do_reset();

    for (int k = 0; k < 40; k++) begin
      f = make_frame(DW'($urandom));
      if ($urandom_range(1)) f = f ^ N'(1 << $urandom_range(N - 1));
      send(f, $urandom_range(60), N);
      release_res(f, $urandom_range(3));
    end

    do_reset();
    for (int k = 0; k < 257; k++) begin
      f = make_frame(DW'($urandom)) ^ N'(1 << $urandom_range(N - 1));
      send(f, 0, N);
      release_res(f, 0);
    end
    chk("err_sat", err_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
